// File: rtl/sata_oob_pkg.sv
// sata_oob_pkg: shared state encoding and SATA primitive constants for the OOB sequencer.
package sata_oob_pkg;
    typedef enum logic [3:0] {
        IDLE, SEND_INIT, WAIT_INIT, SEND_WAKE, WAIT_WAKE,
        WAIT_NOIDLE, SEND_D102, SEND_ALIGN, READY, ERROR
    } state_t;
    localparam logic [31:0] ALIGN   = 32'h7B4A4ABC;
    localparam logic [3:0]  ALIGN_K = 4'b0001;
    localparam logic [31:0] D102    = 32'h4A4A4A4A;
    localparam logic [3:0]  D102_K  = 4'b0000;
    localparam logic [31:0] SYNC    = 32'hB5B5957C;
    localparam logic [3:0]  SYNC_K  = 4'b0001;
endpackage

// File: rtl/sata_oob_ctrl_if.sv
// sata_oob_ctrl_if: channel-facing and user-facing signals of the OOB sequencer.
interface sata_oob_ctrl_if;
    logic        oob_start;
    logic        TXCOMINIT;
    logic        TXCOMWAKE;
    logic        TXCOMFINISH;
    logic        TXELECIDLE;
    logic [31:0] txdata;
    logic [3:0]  txcharisk;
    logic        RXCOMINITDET;
    logic        RXCOMWAKEDET;
    logic        RXELECIDLE;
    logic        RXBYTEISALIGNED;
    logic [31:0] rxdata;
    logic [3:0]  rxcharisk;
    logic [31:0] user_txdata;
    logic [3:0]  user_txcharisk;
    logic        link_up;
    logic        oob_busy;
    logic        oob_error;
    modport master (
        input  oob_start, TXCOMFINISH, RXCOMINITDET, RXCOMWAKEDET, RXELECIDLE,
               RXBYTEISALIGNED, rxdata, rxcharisk, user_txdata, user_txcharisk,
        output TXCOMINIT, TXCOMWAKE, TXELECIDLE, txdata, txcharisk,
               link_up, oob_busy, oob_error
    );
    modport slave (
        output oob_start, TXCOMFINISH, RXCOMINITDET, RXCOMWAKEDET, RXELECIDLE,
               RXBYTEISALIGNED, rxdata, rxcharisk, user_txdata, user_txcharisk,
        input  TXCOMINIT, TXCOMWAKE, TXELECIDLE, txdata, txcharisk,
               link_up, oob_busy, oob_error
    );
endinterface

// File: rtl/sata_oob_timer.sv
// sata_oob_timer: 16-bit wait-state counter, cleared on state entry, flags TIMEOUT_CYCLES-1.
module sata_oob_timer #(
    parameter int TIMEOUT_CYCLES = 32768
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic timeout
);
    logic [15:0] cnt;
    always_ff @(posedge clk) begin
        if (reset || clr) cnt <= '0;
        else cnt <= cnt + 16'd1;
    end
    assign timeout = cnt == 16'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/sata_oob_ctrl.sv
// sata_oob_ctrl: host-side SATA OOB / link-init sequencer driving the GTX channel.
// Define OOB_AUTO_RETRY_EN to retransmit COMINIT up to MAX_RETRY times on WAIT_INIT timeout.
module sata_oob_ctrl
    import sata_oob_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 32768,
    parameter int MAX_RETRY      = 3,
    parameter int SYNC_COUNT     = 3
) (
    input logic            clk,
    input logic            reset,
    sata_oob_ctrl_if.master bus
);
    state_t     state, state_n;
    logic       enter, timeout, dev_init, can_retry;
    logic [7:0] sync_cnt, sync_cnt_n;
    sata_oob_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk(clk), .reset(reset), .clr(enter), .timeout(timeout)
    );
`ifdef OOB_AUTO_RETRY_EN
    logic [7:0] retry;
    assign can_retry = retry < 8'(MAX_RETRY);
    always_ff @(posedge clk) begin
        if (reset || bus.oob_start) retry <= '0;
        else if (state == WAIT_INIT && !bus.RXCOMINITDET && timeout && can_retry) retry <= retry + 8'd1;
    end
`else
    // no retransmission in this build: a WAIT_INIT timeout always ends in ERROR
    assign can_retry = MAX_RETRY < 0;
`endif
    assign dev_init = bus.RXCOMINITDET &&
                      (state inside {SEND_WAKE, WAIT_WAKE, WAIT_NOIDLE, SEND_D102, SEND_ALIGN, READY});
    assign sync_cnt_n = (state == SEND_ALIGN && bus.rxcharisk[0] && bus.rxdata != ALIGN) ? sync_cnt + 8'd1 : 8'd0;
    assign enter = state_n != state || bus.oob_start;
    always_comb begin
        state_n = state;
        case (state)
            SEND_INIT:   state_n = bus.TXCOMFINISH ? WAIT_INIT : state;
            WAIT_INIT:   state_n = bus.RXCOMINITDET ? SEND_WAKE : timeout ? (can_retry ? SEND_INIT : ERROR) : state;
            SEND_WAKE:   state_n = bus.TXCOMFINISH ? WAIT_WAKE : state;
            WAIT_WAKE:   state_n = bus.RXCOMWAKEDET ? WAIT_NOIDLE : timeout ? ERROR : state;
            WAIT_NOIDLE: state_n = !bus.RXELECIDLE ? SEND_D102 : timeout ? ERROR : state;
            SEND_D102:   state_n = (bus.RXBYTEISALIGNED && bus.rxdata == ALIGN && bus.rxcharisk == ALIGN_K) ? SEND_ALIGN
                                   : timeout ? ERROR : state;
            SEND_ALIGN:  state_n = sync_cnt_n == 8'(SYNC_COUNT) ? READY : timeout ? ERROR : state;
            default:     state_n = state;
        endcase
        if (dev_init) state_n = SEND_INIT;
        if (bus.oob_start) state_n = SEND_INIT;
    end
    // outputs are registered from the next state so they track the state register exactly
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            sync_cnt       <= '0;
            bus.TXCOMINIT  <= 1'b0;
            bus.TXCOMWAKE  <= 1'b0;
            bus.TXELECIDLE <= 1'b1;
            bus.txdata     <= '0;
            bus.txcharisk  <= '0;
            bus.link_up    <= 1'b0;
            bus.oob_busy   <= 1'b0;
            bus.oob_error  <= 1'b0;
        end else begin
            state          <= state_n;
            sync_cnt       <= sync_cnt_n;
            bus.TXCOMINIT  <= enter && state_n == SEND_INIT;
            bus.TXCOMWAKE  <= enter && state_n == SEND_WAKE;
            bus.TXELECIDLE <= !(state_n inside {SEND_D102, SEND_ALIGN, READY});
            bus.txdata     <= state_n == SEND_D102 ? D102 : state_n == SEND_ALIGN ? ALIGN
                              : state_n == READY ? (state == READY ? bus.user_txdata : ALIGN) : 32'd0;
            bus.txcharisk  <= state_n == SEND_D102 ? D102_K : state_n == SEND_ALIGN ? ALIGN_K
                              : state_n == READY ? (state == READY ? bus.user_txcharisk : ALIGN_K) : 4'd0;
            bus.link_up    <= state_n == READY;
            bus.oob_busy   <= !(state_n inside {IDLE, READY, ERROR});
            bus.oob_error  <= state_n == ERROR;
        end
    end
endmodule

// File: tb/tb_sata_oob_ctrl.sv
// tb_sata_oob_ctrl: directed self-checking bench for sata_oob_ctrl with TIMEOUT_CYCLES=64.
module tb_sata_oob_ctrl;
    localparam logic [31:0] K_ALIGN = 32'h7B4A4ABC;
    localparam logic [31:0] K_D102  = 32'h4A4A4A4A;
    localparam logic [31:0] K_SYNC  = 32'hB5B5957C;
`ifdef OOB_AUTO_RETRY_EN
    localparam int N_INIT = 4;
`else
    localparam int N_INIT = 1;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    int tests = 0;
    int fails = 0;
    int ninit = 0;
    int nwake = 0;
    always #5 clk = ~clk;
    sata_oob_ctrl_if bus ();
    sata_oob_ctrl #(.TIMEOUT_CYCLES(64), .MAX_RETRY(3), .SYNC_COUNT(3)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    always @(negedge clk) begin
        if (bus.TXCOMINIT === 1'b1) ninit++;
        if (bus.TXCOMWAKE === 1'b1) nwake++;
    end
    // {TXELECIDLE, TXCOMINIT, TXCOMWAKE, link_up, oob_busy, oob_error}
    function automatic logic [5:0] outs();
        return {bus.TXELECIDLE, bus.TXCOMINIT, bus.TXCOMWAKE, bus.link_up, bus.oob_busy, bus.oob_error};
    endfunction
    function automatic logic [35:0] tx();
        return {bus.txcharisk, bus.txdata};
    endfunction
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic idle_inputs();
        bus.oob_start = 0; bus.TXCOMFINISH = 0; bus.RXCOMINITDET = 0; bus.RXCOMWAKEDET = 0;
        bus.RXELECIDLE = 1; bus.RXBYTEISALIGNED = 0; bus.rxdata = 0; bus.rxcharisk = 0;
        bus.user_txdata = 0; bus.user_txcharisk = 0;
    endtask
    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step(2);
        reset = 0;
    endtask
    // one handshake step of the bring-up; stage 6 leaves the bench sending ALIGN
    task automatic stage(input int i);
        case (i)
            0: bus.oob_start = 1;
            1, 3: bus.TXCOMFINISH = 1;
            2: bus.RXCOMINITDET = 1;
            4: bus.RXCOMWAKEDET = 1;
            5: bus.RXELECIDLE = 0;
            6: begin bus.RXBYTEISALIGNED = 1; bus.rxdata = K_ALIGN; bus.rxcharisk = 4'b0001; end
            default: ;
        endcase
        step(1);
        bus.oob_start = 0; bus.TXCOMFINISH = 0; bus.RXCOMINITDET = 0; bus.RXCOMWAKEDET = 0;
    endtask
    task automatic test_reset();
        idle_inputs();
        reset = 1;
        step(1);
        tests++; if (outs() !== 6'b100000) begin fails++; $display("FAIL reset_outs: got %b want %b", outs(), 6'b100000); end
        tests++; if (tx() !== 36'd0) begin fails++; $display("FAIL reset_tx: got %h want %h", tx(), 36'd0); end
        reset = 0;
        step(3);
        tests++; if (outs() !== 6'b100000) begin fails++; $display("FAIL idle_outs: got %b want %b", outs(), 6'b100000); end
    endtask
    task automatic test_bringup();
        int n0, w0;
        do_reset();
        n0 = ninit; w0 = nwake;
        stage(0);
        tests++; if (outs() !== 6'b110010) begin fails++; $display("FAIL up_cominit: got %b want %b", outs(), 6'b110010); end
        step(1);
        tests++; if (outs() !== 6'b100010) begin fails++; $display("FAIL up_cominit_end: got %b want %b", outs(), 6'b100010); end
        step(8);
        stage(1); stage(2);
        tests++; if (outs() !== 6'b101010) begin fails++; $display("FAIL up_comwake: got %b want %b", outs(), 6'b101010); end
        stage(3); stage(4);
        tests++; if (outs() !== 6'b100010) begin fails++; $display("FAIL up_noidle: got %b want %b", outs(), 6'b100010); end
        stage(5);
        tests++; if (outs() !== 6'b000010) begin fails++; $display("FAIL up_d102_outs: got %b want %b", outs(), 6'b000010); end
        tests++; if (tx() !== {4'b0000, K_D102}) begin fails++; $display("FAIL up_d102_tx: got %h want %h", tx(), {4'b0000, K_D102}); end
        stage(6);
        tests++; if (tx() !== {4'b0001, K_ALIGN}) begin fails++; $display("FAIL up_align_tx: got %h want %h", tx(), {4'b0001, K_ALIGN}); end
        bus.user_txdata = 32'h12345678; bus.user_txcharisk = 4'b0000;
        bus.rxdata = K_SYNC; bus.rxcharisk = 4'b0001;
        step(2);
        tests++; if (outs() !== 6'b000010) begin fails++; $display("FAIL up_two_sync: got %b want %b", outs(), 6'b000010); end
        step(1);
        tests++; if (outs() !== 6'b000100) begin fails++; $display("FAIL up_link: got %b want %b", outs(), 6'b000100); end
        step(1);
        tests++; if (tx() !== {4'b0000, 32'h12345678}) begin fails++; $display("FAIL up_user_tx: got %h want %h", tx(), {4'b0000, 32'h12345678}); end
        tests++; if ({ninit - n0, nwake - w0} !== {32'd1, 32'd1}) begin
            fails++; $display("FAIL up_pulse_count: got init=%0d wake=%0d want 1/1", ninit - n0, nwake - w0);
        end
    endtask
    task automatic test_init_timeout();
        int n0;
        logic [5:0] want;
        do_reset();
        n0 = ninit;
        stage(0);
        for (int r = 0; r < N_INIT; r++) begin
            step(3);
            stage(1);
            step(63);
            tests++; if (outs() !== 6'b100010) begin fails++; $display("FAIL init_wait%0d: got %b want %b", r, outs(), 6'b100010); end
            step(1);
            want = (r == N_INIT - 1) ? 6'b100001 : 6'b110010;
            tests++; if (outs() !== want) begin fails++; $display("FAIL init_timeout%0d: got %b want %b", r, outs(), want); end
        end
        tests++; if (ninit - n0 != N_INIT) begin fails++; $display("FAIL init_pulses: got %0d want %0d", ninit - n0, N_INIT); end
    endtask
    task automatic test_wake_timeout();
        do_reset();
        for (int i = 0; i < 4; i++) stage(i);
        step(63);
        tests++; if (outs() !== 6'b100010) begin fails++; $display("FAIL wake_wait: got %b want %b", outs(), 6'b100010); end
        step(1);
        tests++; if (outs() !== 6'b100001) begin fails++; $display("FAIL wake_error: got %b want %b", outs(), 6'b100001); end
        stage(0);
        tests++; if (outs() !== 6'b110010) begin fails++; $display("FAIL wake_restart: got %b want %b", outs(), 6'b110010); end
    endtask
    task automatic test_sync_count();
        logic [31:0] seq [6] = '{K_SYNC, K_SYNC, K_ALIGN, K_SYNC, K_SYNC, K_SYNC};
        logic        lnk [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 7; i++) stage(i);
        for (int i = 0; i < 6; i++) begin
            bus.rxdata = seq[i]; bus.rxcharisk = 4'b0001;
            step(1);
            tests++; if (bus.link_up !== lnk[i]) begin fails++; $display("FAIL sync_word%0d: got %b want %b", i, bus.link_up, lnk[i]); end
        end
    endtask
    task automatic test_dev_cominit();
        int n0;
        n0 = ninit;
        bus.RXCOMINITDET = 1;
        step(1);
        bus.RXCOMINITDET = 0;
        tests++; if (outs() !== 6'b110010) begin fails++; $display("FAIL dev_init: got %b want %b", outs(), 6'b110010); end
        step(1);
        tests++; if (outs() !== 6'b100010) begin fails++; $display("FAIL dev_init_hold: got %b want %b", outs(), 6'b100010); end
        tests++; if (ninit - n0 != 1) begin fails++; $display("FAIL dev_init_pulses: got %0d want 1", ninit - n0); end
    endtask
    task automatic test_mid_reset();
        int n0, w0;
        do_reset();
        for (int i = 0; i < 6; i++) stage(i);
        tests++; if (outs() !== 6'b000010) begin fails++; $display("FAIL mid_d102: got %b want %b", outs(), 6'b000010); end
        reset = 1;
        step(1);
        tests++; if (outs() !== 6'b100000) begin fails++; $display("FAIL mid_reset_outs: got %b want %b", outs(), 6'b100000); end
        tests++; if (tx() !== 36'd0) begin fails++; $display("FAIL mid_reset_tx: got %h want %h", tx(), 36'd0); end
        idle_inputs();
        reset = 0;
        n0 = ninit; w0 = nwake;
        step(20);
        tests++; if ({ninit - n0, nwake - w0} !== {32'd0, 32'd0} || outs() !== 6'b100000) begin
            fails++; $display("FAIL mid_release: got init=%0d wake=%0d outs=%b want 0/0/%b", ninit - n0, nwake - w0, outs(), 6'b100000);
        end
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        test_reset();
        test_bringup();
        test_init_timeout();
        test_wake_timeout();
        test_sync_count();
        test_dev_cominit();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
